// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: slot FSM encoding and
// the active-high hex-to-segment table (bit0 = segment a).
package seg_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   localparam int unsigned NUM_DIG = 4;

   // Entry N holds the pattern for hex digit N.
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg_c
);

   assign o_seg_c = HEX7_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_disp.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous shadow
// capture. Define SEG_LZ_BLANK_EN to blank leading-zero digits 3..1.
module seg_scan_disp
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned BLANK_CYC   = 16,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          AN_ACT_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dsp,
   input  logic [3:0]  dp_in,
   input  logic        upd,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame
);

   localparam int unsigned      DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
   localparam logic [6:0]       SEG_INV    = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic             DP_INV     = SEG_ACT_LOW;
   localparam logic [3:0]       AN_INV     = AN_ACT_LOW ? 4'hF : 4'h0;

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_idx;
   logic [15:0]      r_sh_dsp;
   logic [3:0]       r_sh_dp;
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_tick;
   logic             w_boundary;
   logic [3:0]       w_nib;
   logic [6:0]       w_seg_dec;
   logic             w_lz_blank;
   logic             w_dig_on;

   assign w_tick     = (r_div == DIV_LAST);
   assign w_boundary = w_tick && (r_idx == 2'd3);
   assign w_nib      = r_sh_dsp[{r_idx, 2'b00} +: 4];

   // Slot divider, digit index and frame-synchronous shadow capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div    <= '0;
         r_idx    <= 2'd0;
         r_sh_dsp <= 16'h0000;
         r_sh_dp  <= 4'h0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_boundary && upd) begin
            r_sh_dsp <= dsp;
            r_sh_dp  <= dp_in;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_BLANK;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Every tick reopens the slot in BLANK; BLANK_CYC cycles later it shows.
   always_comb begin
      w_state_nxt = r_state;
      if ((r_state == ST_BLANK) && (r_div == BLANK_LAST)) begin
         w_state_nxt = ST_SHOW;
      end
      if (w_tick) begin
         w_state_nxt = ST_BLANK;
      end
   end

   // A digit is a leading zero when it and every higher nibble are zero.
   always_comb begin
      w_lz_blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      case (r_idx)
         2'd1:    w_lz_blank = (r_sh_dsp[15:4] == 12'h000);
         2'd2:    w_lz_blank = (r_sh_dsp[15:8] == 8'h00);
         2'd3:    w_lz_blank = (r_sh_dsp[15:12] == 4'h0);
         default: w_lz_blank = 1'b0;
      endcase
`endif
   end

   assign w_dig_on = (r_state == ST_SHOW) && !w_lz_blank;

   hex7seg u_hex7seg (
      .i_nib   (w_nib),
      .o_seg_c (w_seg_dec)
   );

   // Registered pin drivers with polarity applied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg   <= SEG_INV;
         dp    <= DP_INV;
         an    <= AN_INV;
         frame <= 1'b0;
      end else begin
         frame <= w_boundary;
         if (w_dig_on) begin
            seg <= w_seg_dec ^ SEG_INV;
            dp  <= r_sh_dp[r_idx] ^ DP_INV;
            an  <= (4'b0001 << r_idx) ^ AN_INV;
         end else begin
            seg <= SEG_INV;
            dp  <= DP_INV;
            an  <= AN_INV;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Scoreboard bench for seg_scan_disp (SCAN_DIV=4, BLANK_CYC=1, active-low pins).
module tb_seg_scan_disp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dsp;
   logic [3:0]  dp_in;
   logic        upd;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame;

   seg_scan_disp #(
      .SCAN_DIV    (4),
      .BLANK_CYC   (1),
      .SEG_ACT_LOW (1'b1),
      .AN_ACT_LOW  (1'b1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .dsp   (dsp),
      .dp_in (dp_in),
      .upd   (upd),
      .seg   (seg),
      .dp    (dp),
      .an    (an),
      .frame (frame)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb[$];
   logic [19:0] m_shadow;
   logic [15:0] m_dsp;
   logic [3:0]  m_dp;
   logic        m_upd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_hex(input logic [3:0] v);
      case (v)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Expected pins per digit, packed as {seg_i, dp_i} in byte i; dark digit = 8'hFF.
   function automatic logic [31:0] exp_frame(input logic [19:0] sh);
      logic [31:0] r;
      logic [15:0] d;
      logic        blank;
      r = '0;
      d = sh[19:4];
      for (int i = 0; i < 4; i++) begin
         blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
         blank = (i > 0) && ((d >> (4 * i)) == 16'h0000);
`endif
         if (blank) r[8*i +: 8] = 8'hFF;
         else       r[8*i +: 8] = {~ref_hex(d[4*i +: 4]), ~sh[i]};
      end
      return r;
   endfunction

   // Output monitor: assembles each displayed frame and checks it against the scoreboard.
   logic [6:0] mon_seg[4];
   logic       mon_dp[4];
   bit         mon_seen[4];
   bit         mon_tear = 1'b0;
   bit         mon_cap  = 1'b0;
   int         run_len  = 0;

   always @(negedge clk) begin : monitor
      int          d;
      logic [31:0] obs;
      logic [31:0] e;
      if (rst) begin
         mon_cap = 1'b0;
         run_len = 0;
      end else begin
         if (an == 4'hF) begin
            run_len++;
         end else begin
            chk("an_onehot", 32'($countones(~an)), 32'd1);
`ifndef SEG_LZ_BLANK_EN
            if (mon_cap && run_len > 0) chk("blank_len", 32'(run_len), 32'd1);
`endif
            run_len = 0;
            if (mon_cap) begin
               d = 0;
               for (int i = 3; i >= 0; i--) if (!an[i]) d = i;
               if (mon_seen[d]) begin
                  if (seg !== mon_seg[d] || dp !== mon_dp[d]) mon_tear = 1'b1;
               end else begin
                  mon_seen[d] = 1'b1;
                  mon_seg[d]  = seg;
                  mon_dp[d]   = dp;
               end
            end
         end
         if (frame) begin
            if (mon_cap) begin
               obs = '0;
               for (int i = 0; i < 4; i++)
                  obs[8*i +: 8] = mon_seen[i] ? {mon_seg[i], mon_dp[i]} : 8'hFF;
               if (sb.size() == 0) begin
                  chk("sb_empty", 32'd0, 32'd1);
               end else begin
                  e = sb.pop_front();
                  chk("frame_data", obs, e);
               end
               chk("frame_tear", 32'(mon_tear), 32'd0);
            end
            mon_cap  = 1'b1;
            mon_tear = 1'b0;
            for (int i = 0; i < 4; i++) mon_seen[i] = 1'b0;
         end
      end
   end

   task automatic wait_frame(output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (frame) begin
            n    = k;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("frame_wait", 32'd0, 32'd1);
   endtask

   // Called on the frame-pulse cycle: record what this frame must show, then drive new inputs mid-frame.
   task automatic on_pulse(input logic [15:0] d, input logic [3:0] p, input logic u, input int dly);
      if (m_upd) m_shadow = {m_dsp, m_dp};
      sb.push_back(exp_frame(m_shadow));
      repeat (dly) @(negedge clk);
      dsp   = d;
      dp_in = p;
      upd   = u;
      m_dsp = d;
      m_dp  = p;
      m_upd = u;
   endtask

   task automatic step(input logic [15:0] d, input logic [3:0] p, input logic u, input int dly);
      int n;
      wait_frame(n);
      on_pulse(d, p, u, dly);
   endtask

   initial begin
      int n;
      bit found;
      dsp = 16'h12AF; dp_in = 4'h0; upd = 1'b1;
      m_dsp = 16'h12AF; m_dp = 4'h0; m_upd = 1'b1; m_shadow = '0;

      repeat (3) @(negedge clk);
      chk("rst_an",    32'(an),    32'hF);
      chk("rst_seg",   32'(seg),   32'h7F);
      chk("rst_dp",    32'(dp),    32'h1);
      chk("rst_frame", 32'(frame), 32'h0);
      rst = 1'b0;

      wait_frame(n);
      chk("first_frame_lat", 32'(n), 32'd16);
      on_pulse(16'h1234, 4'h0, 1'b1, 3);
      step(16'hEEEE, 4'h0, 1'b0, 5);
      step(16'hEEEE, 4'h0, 1'b0, 2);
      step(16'hEEEE, 4'h0, 1'b0, 12);
      step(16'hEEEE, 4'h0, 1'b1, 4);
      step(16'h0000, 4'h0, 1'b1, 1);
      step(16'hFFFF, 4'hF, 1'b1, 9);
      step(16'h00A5, 4'b1000, 1'b1, 6);
      for (int k = 0; k < 3; k++)
         step(16'($urandom), 4'($urandom_range(0, 15)), 1'b1, int'($urandom_range(1, 14)));
      wait_frame(n);

      // Reset while digit 2 is being shown.
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (an == 4'b1011) begin
            found = 1'b1;
            break;
         end
      end
      chk("find_digit2", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_an",    32'(an),    32'hF);
      chk("midrst_seg",   32'(seg),   32'h7F);
      chk("midrst_dp",    32'(dp),    32'h1);
      chk("midrst_frame", 32'(frame), 32'h0);
      sb.delete();
      dsp = 16'h5555; dp_in = 4'h0; upd = 1'b1;
      m_dsp = 16'h5555; m_dp = 4'h0; m_upd = 1'b1; m_shadow = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (an != 4'hF) begin
            n = k;
            break;
         end
      end
      chk("rst_first_lat", 32'(n),   32'd2);
      chk("rst_first_an",  32'(an),  32'h0000_000E);
      chk("rst_zero_seg",  32'(seg), 32'h40);
      chk("rst_zero_dp",   32'(dp),  32'h1);

      wait_frame(n);
      chk("rst_frame_lat", 32'(n), 32'd14);
      on_pulse(16'h9C0D, 4'b0101, 1'b1, 7);
      step(16'h0000, 4'h0, 1'b0, 2);
      wait_frame(n);
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_disp.md
SEG_SCAN_DISP -- requirements
Module: seg_scan_disp

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 16: anode-off cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 Parameter SEG_ACT_LOW, default 1: 1 means seg/dp are active-low.
REQ-004 Parameter AN_ACT_LOW, default 1: 1 means an is active-low.
REQ-005 Port clk, input, 1: sole clock.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port dsp, input, 16: four hex nibbles from the debug data selector; nibble 0 is dsp[3:0].
REQ-008 Port dp_in, input, 4: per-digit decimal point request; bit i belongs to digit i.
REQ-009 Port upd, input, 1: 1 = capture dsp/dp_in at each frame boundary; 0 = freeze the shadow.
REQ-010 Port seg, output, 7: segments a..g as seg[0]..seg[6].
REQ-011 Port dp, output, 1: decimal point.
REQ-012 Port an, output, 4: digit enables; an[0] is the rightmost digit.
REQ-013 Port frame, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-014 Divider counter counts 0..SCAN_DIV-1 and wraps; a tick occurs on the cycle where count = SCAN_DIV-1.
REQ-015 Digit index counts 0,1,2,3,0 and advances only on tick.
REQ-016 Frame boundary is the tick where index advances 3->0; frame is high on the following cycle only.
REQ-017 At a frame boundary with upd=1, shadow <= {dsp, dp_in}; with upd=0, shadow holds; dsp changes mid-frame never tear the display.
REQ-018 Two-state FSM per slot: BLANK holds all anodes inactive for BLANK_CYC cycles after each tick, then SHOW drives the selected anode active until the next tick.
REQ-019 In SHOW, seg = hex7seg(shadow nibble[index]) and dp = shadow dp[index]; polarity is per SEG_ACT_LOW / AN_ACT_LOW.
REQ-020 seg, dp and an are registered, changing one clk after the internal state change, with no combinational path from dsp to outputs.
REQ-021 Decode is standard hex: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71 (active-high, bit0=a).
REQ-022 An upd change on the boundary cycle is sampled on that cycle; no other simultaneous-event cases exist.

Reset
REQ-023 With rst high, divider=0, index=0, state=BLANK, shadow=0, an all inactive, seg/dp all inactive, frame=0.
REQ-024 Reset asserted mid-slot or mid-frame aborts immediately; after release, scanning restarts at digit 0 in BLANK, and the shadow stays 0 until the first frame boundary.

Configuration
REQ-025 Macro SEG_LZ_BLANK_EN defined: digits 3..1 are blanked (an inactive throughout the slot) while they and all higher nibbles of the shadow are 0, and digit 0 is always shown; a blanked digit also suppresses its dp.
REQ-026 Macro SEG_LZ_BLANK_EN undefined: all four digits are always shown, leading zeros included.

Structure
REQ-027 Shared package seg_pkg holds the 16-entry hex-to-segment constant table and the FSM state encoding (BLANK=0, SHOW=1).
REQ-028 One sub-module, hex7seg (4-bit in, 7-bit active-high out, combinational), is instantiated once; polarity inversion lives in seg_scan_disp.

Verification (SCAN_DIV=4, BLANK_CYC=1, both polarities active-low)
REQ-029 Release reset with dsp=0x12AF, upd=1: frame pulses after 16 cycles; the next frame shows an=1110 seg=~0x71, an=1101 seg=~0x77, an=1011 seg=~0x5B, an=0111 seg=~0x06.
REQ-030 Capture dsp=0x1234, set upd=0, change dsp to 0xEEEE: the display stays 1234 for 3 frames; set upd=1: the display shows EEEE from the following frame.
REQ-031 Change dsp 0x0000->0xFFFF mid-frame: the current frame is entirely old data and the next frame is entirely new; no mixed frame occurs.
REQ-032 Check every slot: an is all-1 for exactly 1 cycle after each tick and never has two zeros.
REQ-033 With SEG_LZ_BLANK_EN and dsp=0x00A5, dp_in=4'b1000: digits 3 and 2 are dark with dp off; digit 1=A and digit 0=5 are shown. Without the macro, digit 3 shows 0 with dp on.
REQ-034 Assert rst in the SHOW slot of digit 2: outputs go inactive in the same cycle; after release, the first active anode is an[0] after BLANK_CYC+1 cycles.
